// File: rtl/window_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : window_counter_pkg
// Description : Shared mode encodings and default sizing for window_counter.
// Revision    : 1.0
// ============================================================================
package window_counter_pkg;

    localparam logic MODE_WRAP    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    localparam int DEFAULT_NUM_BITS = 10;
    localparam int DEFAULT_NUM_CH   = 4;

endpackage : window_counter_pkg
`default_nettype wire

// File: rtl/window_counter_ch.sv
`default_nettype none
// ============================================================================
// Module      : window_counter_ch
// Description : One windowed sample counter with done level and entry pulse.
// Revision    : 1.0
// ============================================================================
module window_counter_ch
    import window_counter_pkg::*;
#(
    parameter int NUM_BITS = DEFAULT_NUM_BITS
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                cnt_up,
    input  logic                clear,
    input  logic [NUM_BITS-1:0] rollover_val,
    input  logic                mode,
    output logic [NUM_BITS-1:0] count,
    output logic                done,
    output logic                pulse,
    output logic                done_next
);

    localparam logic [NUM_BITS-1:0] c_one = NUM_BITS'(1);

    logic [NUM_BITS-1:0] r_count;
    logic                r_done;
    logic                r_pulse;

    logic [NUM_BITS-1:0] w_count_next;
    logic                w_advance;
    logic                w_done_next;
    logic                w_pulse_next;
    logic                w_window_on;

    assign w_window_on = (rollover_val != '0);

    always_comb begin
        w_count_next = r_count;
        w_advance    = 1'b0;
        if (clear) begin
            w_count_next = '0;
        end else if (cnt_up && w_window_on) begin
            // A count above a freshly lowered window restarts like a wrap.
            if (r_count == rollover_val) begin
                if (mode == MODE_WRAP) begin
                    w_count_next = c_one;
                    w_advance    = 1'b1;
                end
            end else if (r_count > rollover_val) begin
                w_count_next = c_one;
                w_advance    = 1'b1;
            end else begin
                w_count_next = r_count + c_one;
                w_advance    = 1'b1;
            end
        end
    end

    // A pulse marks either a fresh arrival or a wrap that lands straight back on the window end.
    assign w_done_next  = w_window_on && (w_count_next == rollover_val);
    assign w_pulse_next = w_done_next && (w_advance || !r_done);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_count <= '0;
            r_done  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_done  <= w_done_next;
            r_pulse <= w_pulse_next;
        end
    end

    assign count     = r_count;
    assign done      = r_done;
    assign pulse     = r_pulse;
    assign done_next = w_done_next;

endmodule : window_counter_ch
`default_nettype wire

// File: rtl/window_counter.sv
`default_nettype none
// ============================================================================
// Module      : window_counter
// Description : NUM_CH independent windowed counters with a registered all_done.
// Revision    : 1.0
// ============================================================================
module window_counter
    import window_counter_pkg::*;
#(
    parameter int NUM_BITS = DEFAULT_NUM_BITS,
    parameter int NUM_CH   = DEFAULT_NUM_CH
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic [NUM_CH-1:0]          cnt_up,
    input  logic [NUM_CH-1:0]          clear,
    input  logic [NUM_BITS-1:0]        rollover_val,
    input  logic                       mode,
    output logic [NUM_CH*NUM_BITS-1:0] count_out,
    output logic [NUM_CH-1:0]          window_done,
    output logic [NUM_CH-1:0]          window_pulse,
    output logic                       all_done
);

    logic [NUM_CH-1:0] w_done_next;
    logic              r_all_done;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            window_counter_ch #(
                .NUM_BITS (NUM_BITS)
            ) u_ch (
                .clk          (clk),
                .n_rst        (n_rst),
                .cnt_up       (cnt_up[gi]),
                .clear        (clear[gi]),
                .rollover_val (rollover_val),
                .mode         (mode),
                .count        (count_out[gi*NUM_BITS +: NUM_BITS]),
                .done         (window_done[gi]),
                .pulse        (window_pulse[gi]),
                .done_next    (w_done_next[gi])
            );
        end
    endgenerate

    // Built from next-state done so it lines up with the registered window_done bits.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_all_done <= 1'b0;
        end else begin
            r_all_done <= (&w_done_next) && (mode == MODE_ONESHOT);
        end
    end

    assign all_done = r_all_done;

endmodule : window_counter
`default_nettype wire
